// File: rtl/lcd_pkg.sv
// Shared LCD geometry and the frame streamer's state encoding.
package lcd_pkg;

  localparam int HALF_COLS   = 64;
  localparam int LCD_COLS    = 2 * HALF_COLS;
  localparam int FRAME_BYTES = 1024;
  localparam int LCD_PAGES   = FRAME_BYTES / LCD_COLS;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} stream_state_t;

endpackage

// File: rtl/lcd_pixel_column.sv
// Maps one LCD column of one page onto playfield cells and returns its 8-pixel byte.
module lcd_pixel_column
  import lcd_pkg::*;
#(
  parameter int COLS  = 10,
  parameter int ROWS  = 10,
  parameter int CELL  = 6,
  parameter int X_OFF = 34
) (
  input  logic [$clog2(LCD_PAGES)-1:0] page,
  input  logic [$clog2(LCD_COLS)-1:0]  x,
  input  logic [6:0]                   cell_col,
  input  logic [6:0]                   row_base,
  input  logic [6:0]                   row_sub,
  input  logic [ROWS*COLS-1:0]         cell_table,
  output logic [7:0]                   pix_byte
);

  localparam int IW        = $clog2(ROWS*COLS);
  localparam int FIELD_END = X_OFF + COLS*CELL;

  logic [IW-1:0] idx;

  // The cell row is walked across the 8 pixel rows of the page with a small
  // mod-CELL counter seeded from the page-start values, so no divider is needed.
  always_comb begin
    int r, s, y, xi;
    pix_byte = '0;
    idx      = '0;
    r        = int'(row_base);
    s        = int'(row_sub);
    xi       = int'(x);
    for (int b = 0; b < 8; b++) begin
      y = int'(page) * 8 + b;
      if (y < ROWS*CELL) begin
        if (xi == X_OFF-1 || xi == FIELD_END) begin
          pix_byte[b] = 1'b1;
        end else if (xi >= X_OFF && xi < FIELD_END) begin
          idx         = IW'(r*COLS + int'(cell_col));
          pix_byte[b] = cell_table[idx];
        end
      end
      if (s == CELL-1) begin
        s = 0;
        r = r + 1;
      end else begin
        s = s + 1;
      end
    end
  end

endmodule

// File: rtl/lcd_frame_streamer.sv
// Snapshots the playfield and streams the rendered 128x64 frame to the LCD byte by byte.
module lcd_frame_streamer
  import lcd_pkg::*;
#(
  parameter int COLS  = 10,
  parameter int ROWS  = 10,
  parameter int CELL  = 6,
  parameter int X_OFF = 34
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ROWS*COLS-1:0] game_table,
  input  logic                 change,
  input  logic                 en_tran,
  output logic [7:0]           data_out,
  output logic                 data_valid,
  output logic                 frame_done
);

  localparam int PW        = $clog2(LCD_PAGES);
  localparam int XW        = $clog2(LCD_COLS);
  localparam int FIELD_END = X_OFF + COLS*CELL;

  stream_state_t        state, state_nxt;
  logic [ROWS*COLS-1:0] snapshot, table_src;
  logic [PW-1:0]        page, page_nxt;
  logic [XW-1:0]        col, col_nxt;
  logic [6:0]           cell_col, cell_col_nxt, col_sub, col_sub_nxt;
  logic [6:0]           row_base, row_base_nxt, row_sub, row_sub_nxt;
  logic                 load_byte, last_byte;
  logic [7:0]           pix_byte;

  assign last_byte  = (int'(page) == LCD_PAGES-1) && (int'(col) == LCD_COLS-1);
  assign table_src  = (state == LOAD) ? game_table : snapshot;
  assign data_valid = (state == EMIT);
  assign frame_done = (state == DONE);

  // The position registers describe the byte on data_out; the mapper looks at
  // the *_nxt position so the following byte is ready without a bubble.
  always_comb begin
    int rb, rs;
    state_nxt    = state;
    page_nxt     = page;
    col_nxt      = col;
    cell_col_nxt = cell_col;
    col_sub_nxt  = col_sub;
    row_base_nxt = row_base;
    row_sub_nxt  = row_sub;
    load_byte    = 1'b0;
    rb           = int'(row_base);
    rs           = int'(row_sub);
    case (state)
      IDLE: if (change) state_nxt = LOAD;
      LOAD: begin
        page_nxt     = '0;
        col_nxt      = '0;
        cell_col_nxt = '0;
        col_sub_nxt  = '0;
        row_base_nxt = '0;
        row_sub_nxt  = '0;
        load_byte    = 1'b1;
        state_nxt    = EMIT;
      end
      EMIT: if (en_tran) begin
        if (last_byte) begin
          state_nxt = DONE;
        end else begin
          load_byte = 1'b1;
          if (int'(col) == LCD_COLS-1) begin
            col_nxt      = '0;
            cell_col_nxt = '0;
            col_sub_nxt  = '0;
            page_nxt     = page + 1'b1;
            for (int i = 0; i < 8; i++) begin
              if (rs == CELL-1) begin
                rs = 0;
                rb = rb + 1;
              end else begin
                rs = rs + 1;
              end
            end
            row_base_nxt = 7'(rb);
            row_sub_nxt  = 7'(rs);
          end else begin
            col_nxt = col + 1'b1;
            if (int'(col) >= X_OFF && int'(col) < FIELD_END) begin
              if (int'(col_sub) == CELL-1) begin
                col_sub_nxt  = '0;
                cell_col_nxt = cell_col + 7'd1;
              end else begin
                col_sub_nxt = col_sub + 7'd1;
              end
            end
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      page     <= '0;
      col      <= '0;
      cell_col <= '0;
      col_sub  <= '0;
      row_base <= '0;
      row_sub  <= '0;
      snapshot <= '0;
      data_out <= 8'h00;
    end else begin
      state    <= state_nxt;
      page     <= page_nxt;
      col      <= col_nxt;
      cell_col <= cell_col_nxt;
      col_sub  <= col_sub_nxt;
      row_base <= row_base_nxt;
      row_sub  <= row_sub_nxt;
      if (state == LOAD) snapshot <= game_table;
      if (load_byte) data_out <= pix_byte;
    end
  end

  lcd_pixel_column #(
    .COLS (COLS),
    .ROWS (ROWS),
    .CELL (CELL),
    .X_OFF(X_OFF)
  ) u_pixel_column (
    .page      (page_nxt),
    .x         (col_nxt),
    .cell_col  (cell_col_nxt),
    .row_base  (row_base_nxt),
    .row_sub   (row_sub_nxt),
    .cell_table(table_src),
    .pix_byte  (pix_byte)
  );

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Scoreboard bench for lcd_frame_streamer: expected frames are queued when a frame
// is requested and popped as bytes are accepted.
module tb_lcd_frame_streamer;

  localparam int COLS  = 10;
  localparam int ROWS  = 10;
  localparam int CELL  = 6;
  localparam int X_OFF = 34;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [ROWS*COLS-1:0] game_table = '0;
  logic                 change = 1'b0;
  logic                 en_tran = 1'b1;
  logic [7:0]           data_out;
  logic                 data_valid;
  logic                 frame_done;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] exp_q[$];
  logic [7:0] captured[1024];

  always #5 clk = ~clk;

  lcd_frame_streamer #(
    .COLS (COLS),
    .ROWS (ROWS),
    .CELL (CELL),
    .X_OFF(X_OFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .game_table(game_table),
    .change    (change),
    .en_tran   (en_tran),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_done(frame_done)
  );

  // Reference pixel rule written directly from the geometry, using plain division.
  function automatic logic [7:0] modelByte(input logic [ROWS*COLS-1:0] tbl, input int page, input int col);
    logic [7:0] b;
    int y;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      y = page*8 + i;
      if (y < ROWS*CELL) begin
        if (col == X_OFF-1 || col == X_OFF+COLS*CELL) b[i] = 1'b1;
        else if (col >= X_OFF && col < X_OFF+COLS*CELL)
          b[i] = tbl[(y/CELL)*COLS + (col-X_OFF)/CELL];
      end
    end
    return b;
  endfunction

  task automatic pushFrame(input logic [ROWS*COLS-1:0] tbl);
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 128; c++)
        exp_q.push_back(modelByte(tbl, p, c));
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [ROWS*COLS-1:0] tbl, input logic chg);
    @(negedge clk);
    game_table = tbl;
    change     = chg;
  endtask

  // Streams until 'frames' frame_done pulses (or a planted reset), checking every
  // accepted byte against the scoreboard plus handshake timing.
  task automatic runStream(input int frames, input bit pulse_change, input int stall_at,
                           input int reset_at, input int toggle_at, input logic [ROWS*COLS-1:0] new_tbl);
    int cyc, done_cnt, fbytes, last_acc, done_cyc, stall_left;
    bit stalled, in_frame, toggled, capture_now;
    logic [7:0] held, exp_byte;
    cyc = 0; done_cnt = 0; fbytes = 0; last_acc = -10; done_cyc = -10; stall_left = 0;
    stalled = 0; in_frame = 0; toggled = 0; held = '0; exp_byte = '0;
    while (done_cnt < frames && cyc < 2500*frames) begin
      @(negedge clk);
      cyc++;
      if (pulse_change && cyc == 1) change = 1'b0;
      if (frame_done) begin
        checkOutput("done_after_last_accept", cyc, last_acc + 1);
        checkOutput("frame_bytes", fbytes, 1024);
        checkOutput("valid_low_in_done", data_valid, 1'b0);
        done_cnt++;
        done_cyc = cyc;
        fbytes   = 0;
        in_frame = 0;
      end
      if (data_valid && !in_frame) begin
        in_frame = 1;
        checkOutput("first_byte_latency", cyc, (done_cnt == 0) ? 2 : done_cyc + 3);
      end
      if (reset_at >= 0 && fbytes == reset_at && data_valid) begin
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid_low", data_valid, 1'b0);
        checkOutput("reset_no_done", frame_done, 1'b0);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          checkOutput("post_reset_idle_valid", data_valid, 1'b0);
          checkOutput("post_reset_no_done", frame_done, 1'b0);
        end
        exp_q.delete();
        return;
      end
      capture_now = 0;
      if (stall_at >= 0 && !stalled && fbytes == stall_at && data_valid) begin
        stalled     = 1;
        stall_left  = 5;
        held        = data_out;
        capture_now = 1;
      end
      if (stall_left > 0) begin
        en_tran = 1'b0;
        stall_left--;
        if (!capture_now) begin
          checkOutput("stall_data_hold", data_out, held);
          checkOutput("stall_valid_hold", data_valid, 1'b1);
        end
      end else begin
        en_tran = 1'b1;
      end
      if (data_valid && en_tran) begin
        checkOutput("scoreboard_has_entry", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_byte = exp_q.pop_front();
          checkOutput($sformatf("byte_%0d", fbytes), data_out, exp_byte);
        end
        if (fbytes < 1024) captured[fbytes] = data_out;
        fbytes++;
        last_acc = cyc;
        if (toggle_at >= 0 && !toggled && fbytes == toggle_at) begin
          game_table = new_tbl;
          pushFrame(new_tbl);
          toggled = 1;
        end
      end
    end
    checkOutput("frames_completed", done_cnt, frames);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [ROWS*COLS-1:0] tbl, tbl2;

    // Reset state and a quiet idle period.
    repeat (2) @(negedge clk);
    checkOutput("reset_data_out", data_out, 8'h00);
    checkOutput("reset_data_valid", data_valid, 1'b0);
    checkOutput("reset_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_no_valid", data_valid, 1'b0);

    // Empty playfield: border only.
    tbl = '0;
    pushFrame(tbl);
    applyStimulus(tbl, 1'b1);
    runStream(1, 1, -1, -1, -1, '0);
    checkOutput("t1_left_border_p0", captured[33], 8'hFF);
    checkOutput("t1_right_border_p0", captured[94], 8'hFF);
    checkOutput("t1_right_border_p6", captured[6*128+94], 8'hFF);
    checkOutput("t1_left_border_p7", captured[7*128+33], 8'h0F);
    checkOutput("t1_right_border_p7", captured[7*128+94], 8'h0F);
    checkOutput("t1_outside_left", captured[32], 8'h00);
    checkOutput("t1_outside_right", captured[95], 8'h00);
    checkOutput("t1_field_empty", captured[64], 8'h00);

    // Top-left cell.
    tbl = '0; tbl[0] = 1'b1;
    pushFrame(tbl);
    applyStimulus(tbl, 1'b1);
    runStream(1, 1, -1, -1, -1, '0);
    checkOutput("t2_cell_first_col", captured[34], 8'h3F);
    checkOutput("t2_cell_last_col", captured[39], 8'h3F);
    checkOutput("t2_next_cell", captured[40], 8'h00);
    checkOutput("t2_below", captured[128+34], 8'h00);

    // Row 1, column 9: straddles pages 0 and 1.
    tbl = '0; tbl[1*COLS+9] = 1'b1;
    pushFrame(tbl);
    applyStimulus(tbl, 1'b1);
    runStream(1, 1, -1, -1, -1, '0);
    checkOutput("t3_p0_first", captured[88], 8'hC0);
    checkOutput("t3_p0_last", captured[93], 8'hC0);
    checkOutput("t3_p1_first", captured[128+88], 8'h0F);
    checkOutput("t3_p1_before", captured[128+87], 8'h00);

    // Backpressure at byte 100.
    tbl = '0; tbl[0] = 1'b1; tbl[57] = 1'b1;
    pushFrame(tbl);
    applyStimulus(tbl, 1'b1);
    runStream(1, 1, 100, -1, -1, '0);

    // Table changes mid-frame with change held: frame 1 old table, frame 2 new.
    tbl  = '0; tbl[55] = 1'b1;
    tbl2 = tbl; tbl2[55] = 1'b0; tbl2[90] = 1'b1;
    pushFrame(tbl);
    applyStimulus(tbl, 1'b1);
    runStream(2, 0, -1, -1, 500, tbl2);
    change = 1'b0;
    checkOutput("t5_new_cell_p6", captured[6*128+34], 8'hC0);
    checkOutput("t5_new_cell_p7", captured[7*128+34], 8'h0F);
    checkOutput("t5_old_cell_gone", captured[3*128+64], 8'h00);

    // Reset in the middle of a frame, then a clean restart.
    tbl = '0; tbl[0] = 1'b1;
    pushFrame(tbl);
    applyStimulus(tbl, 1'b1);
    runStream(1, 1, -1, 300, -1, '0);
    pushFrame(tbl);
    applyStimulus(tbl, 1'b1);
    runStream(1, 1, -1, -1, -1, '0);
    checkOutput("t6_restart_first_byte", captured[0], 8'h00);
    checkOutput("t6_restart_cell", captured[34], 8'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
